// File: rtl/booth_pkg.sv
// Shared types and the radix-4 Booth recoding function for the sequential multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        ZERO,
        POS1,
        POS2,
        NEG1,
        NEG2
    } booth_digit_e;

    // Window is {mr[2i+1], mr[2i], mr[2i-1]}.
    function automatic booth_digit_e booth_recode(input logic [2:0] window);
        case (window)
            3'b001, 3'b010: booth_recode = POS1;
            3'b011:         booth_recode = POS2;
            3'b100:         booth_recode = NEG2;
            3'b101, 3'b110: booth_recode = NEG1;
            default:        booth_recode = ZERO;
        endcase
    endfunction

endpackage

// File: rtl/booth_r4_step.sv
// One radix-4 Booth iteration: adds digit*mcand to the partial product, W+1 bits wide.
module booth_r4_step
    import booth_pkg::*;
#(
    parameter int W = 10
) (
    input  logic [W:0]   acc,
    input  logic [W-1:0] mcand,
    input  logic [2:0]   window,
    output logic [W:0]   acc_next
);

    localparam logic [W:0] ONE = {{W{1'b0}}, 1'b1};
    localparam logic [W:0] TWO = {{(W-1){1'b0}}, 2'b10};

    logic [W:0] m_ext;

    assign m_ext = {mcand[W-1], mcand};

    always_comb begin
        // NOTE: default assigned first so no path through the case can infer a latch.
        acc_next = acc;
        case (booth_recode(window))
            POS1:    acc_next = acc + m_ext;
            POS2:    acc_next = acc + (m_ext << 1);
            NEG1:    acc_next = acc + (~m_ext + ONE);
            NEG2:    acc_next = acc + ((~m_ext << 1) + TWO);
            default: acc_next = acc;
        endcase
    end

endmodule

// File: rtl/booth_r4_seq_mul.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on operands and product.
module booth_r4_seq_mul
    import booth_pkg::*;
#(
    parameter int N = 8
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           clear_i,
    input  logic           valid_i,
    output logic           ready_o,
    input  logic           signed_i,
    input  logic [N-1:0]   multiplicand_i,
    input  logic [N-1:0]   multiplier_i,
    output logic           valid_o,
    input  logic           ready_i,
    output logic [2*N-1:0] product_o,
    output logic           busy_o
);

    localparam int W    = N + 2;
    localparam int ITER = W / 2;
    localparam int CW   = $clog2(ITER);

    state_e         state_q, state_d;
    logic [W:0]     acc_q;
    logic [W-1:0]   mr_q, mcand_q;
    logic           mr_prev_q;
    logic [CW-1:0]  count_q;
    logic [2*N-1:0] product_q;

    logic [W:0]     acc_sum;
    logic [2*W:0]   shifted;
    logic           last_iter, accept;
    logic [W-1:0]   mcand_ext, mr_ext;

    booth_r4_step #(.W(W)) u_step (
        .acc      (acc_q),
        .mcand    (mcand_q),
        .window   ({mr_q[1:0], mr_prev_q}),
        .acc_next (acc_sum)
    );

    // The {acc, mr} pair shifts as one arithmetic register so product bits fill mr from the top.
    assign shifted   = $signed({acc_sum, mr_q}) >>> 2;
    assign last_iter = (count_q == CW'(ITER - 1));
    assign accept    = valid_i && ready_o && !clear_i;
    assign mcand_ext = {{2{signed_i & multiplicand_i[N-1]}}, multiplicand_i};
    assign mr_ext    = {{2{signed_i & multiplier_i[N-1]}}, multiplier_i};
    assign product_o = product_q;

    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 1'b0;
        busy_o  = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = 1'b1;
                if (accept) state_d = CALC;
            end
            CALC: begin
                busy_o = 1'b1;
                if (last_iter) state_d = DONE;
            end
            DONE: begin
                valid_o = 1'b1;
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q     <= '0;
            mr_q      <= '0;
            mcand_q   <= '0;
            mr_prev_q <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else if (!clear_i) begin
            if (state_q == IDLE && accept) begin
                mcand_q   <= mcand_ext;
                mr_q      <= mr_ext;
                acc_q     <= '0;
                mr_prev_q <= 1'b0;
                count_q   <= '0;
            end else if (state_q == CALC) begin
                acc_q     <= shifted[2*W:W];
                mr_q      <= shifted[W-1:0];
                mr_prev_q <= mr_q[1];
                count_q   <= count_q + {{(CW-1){1'b0}}, 1'b1};
                if (last_iter) product_q <= shifted[2*N-1:0];
            end
        end
    end

endmodule

// File: tb/tb_booth_r4_seq_mul.sv
// Scoreboard bench for booth_r4_seq_mul: N=8 directed cases and an N=16 random sweep.
module tb_booth_r4_seq_mul;

    typedef struct {
        logic [31:0] exp;
        int          acc_cyc;
    } item_t;

    logic clk, rst_ni;
    int   cycle;
    int   total, bad;

    logic        clear8, valid_i8, ready_o8, signed8, valid_o8, ready_i8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;

    logic        clear16, valid_i16, ready_o16, signed16, valid_o16, ready_i16, busy16;
    logic [15:0] a16, b16;
    logic [31:0] product16;

    logic  vprev8, vprev16;
    item_t q8[$];
    item_t q16[$];

    booth_r4_seq_mul #(.N(8)) dut8 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear8), .valid_i(valid_i8),
        .ready_o(ready_o8), .signed_i(signed8), .multiplicand_i(a8),
        .multiplier_i(b8), .valid_o(valid_o8), .ready_i(ready_i8),
        .product_o(product8), .busy_o(busy8)
    );

    booth_r4_seq_mul #(.N(16)) dut16 (
        .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear16), .valid_i(valid_i16),
        .ready_o(ready_o16), .signed_i(signed16), .multiplicand_i(a16),
        .multiplier_i(b16), .valid_o(valid_o16), .ready_i(ready_i16),
        .product_o(product16), .busy_o(busy16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required to finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no matching event, required one", name);
    endtask

    // Reference: interpret operands as integers, multiply, reduce modulo 2^(2n).
    function automatic logic [31:0] ref_mul(input int n, input logic s,
                                            input logic [15:0] a, input logic [15:0] b);
        longint ax, bx, p;
        logic [63:0] mask;
        ax = longint'(a) & ((longint'(1) << n) - 1);
        bx = longint'(b) & ((longint'(1) << n) - 1);
        if (s && a[n-1]) ax = ax - (longint'(1) << n);
        if (s && b[n-1]) bx = bx - (longint'(1) << n);
        p    = ax * bx;
        mask = (64'd1 << (2 * n)) - 64'd1;
        return 32'(64'(p) & mask);
    endfunction

    always @(negedge clk) begin
        if (rst_ni) begin
            if (valid_o8 && !vprev8) begin
                if (q8.size() == 0) fail_now("unexpected_valid8");
                else check("latency8", 64'(cycle - q8[0].acc_cyc), 64'(5));
            end
            if (valid_o8 && ready_i8 && q8.size() != 0) begin
                check("product8", 64'(product8), 64'(q8[0].exp[15:0]));
                void'(q8.pop_front());
            end
        end
        vprev8 <= valid_o8;
    end

    always @(negedge clk) begin
        if (rst_ni) begin
            if (valid_o16 && !vprev16) begin
                if (q16.size() == 0) fail_now("unexpected_valid16");
                else check("latency16", 64'(cycle - q16[0].acc_cyc), 64'(9));
            end
            if (valid_o16 && ready_i16 && q16.size() != 0) begin
                check("product16", 64'(product16), 64'(q16[0].exp));
                void'(q16.pop_front());
            end
        end
        vprev16 <= valid_o16;
    end

    task automatic issue(input bit wide, input logic s, input logic [15:0] a, input logic [15:0] b);
        item_t it;
        bit    ok;
        ok = 1'b0;
        @(posedge clk); #1;
        if (wide) begin
            signed16 = s; a16 = a; b16 = b; valid_i16 = 1'b1;
        end else begin
            signed8 = s; a8 = a[7:0]; b8 = b[7:0]; valid_i8 = 1'b1;
        end
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (wide ? (ready_o16 && !clear16) : (ready_o8 && !clear8)) begin
                ok         = 1'b1;
                it.exp     = ref_mul(wide ? 16 : 8, s, a, b);
                it.acc_cyc = cycle + 1;
                if (wide) q16.push_back(it);
                else      q8.push_back(it);
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk); #1;
        valid_i8  = 1'b0;
        valid_i16 = 1'b0;
    endtask

    task automatic drain(input bit wide);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (wide ? (q16.size() == 0 && !valid_o16) : (q8.size() == 0 && !valid_o8)) ok = 1'b1;
        end
        if (!ok) fail_now("drain_timeout");
    endtask

    initial begin
        logic [15:0] corners [5];
        logic [15:0] a, b;
        logic        s;
        bit          seen;

        total = 0; bad = 0;
        corners[0] = 16'h8000; corners[1] = 16'hFFFF; corners[2] = 16'h0000;
        corners[3] = 16'h7FFF; corners[4] = 16'h0001;
        rst_ni  = 1'b0;
        clear8  = 1'b0; valid_i8  = 1'b0; signed8  = 1'b0; a8  = '0; b8  = '0; ready_i8  = 1'b1;
        clear16 = 1'b0; valid_i16 = 1'b0; signed16 = 1'b0; a16 = '0; b16 = '0; ready_i16 = 1'b1;

        #2;
        check("reset_ready8",   64'(ready_o8), 64'(1));
        check("reset_valid8",   64'(valid_o8), 64'(0));
        check("reset_busy8",    64'(busy8), 64'(0));
        check("reset_product8", 64'(product8), 64'(0));
        check("reset_product16", 64'(product16), 64'(0));
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b1;

        // Signed corner and unsigned/signed pairs
        issue(1'b0, 1'b1, 16'h0080, 16'h0080);
        issue(1'b0, 1'b0, 16'h00FF, 16'h00FF);
        issue(1'b0, 1'b0, 16'h00C8, 16'h0003);
        issue(1'b0, 1'b1, 16'h00C8, 16'h0003);
        drain(1'b0);

        // Backpressure in DONE
        ready_i8 = 1'b0;
        issue(1'b0, 1'b1, 16'h00FF, 16'h007F);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = valid_o8;
        end
        if (!seen) fail_now("bp_valid_timeout");
        for (int i = 0; i < 3; i++) begin
            if (i != 0) @(negedge clk);
            check("bp_product", 64'(product8), 64'(16'hFF81));
            check("bp_ready",   64'(ready_o8), 64'(0));
            check("bp_valid",   64'(valid_o8), 64'(1));
        end
        @(posedge clk); #1 ready_i8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_ready", 64'(ready_o8), 64'(1));
        check("bp_release_valid", 64'(valid_o8), 64'(0));

        // Reset in the middle of CALC
        issue(1'b0, 1'b0, 16'h005A, 16'h0033);
        @(posedge clk); #1;
        check("midcalc_busy", 64'(busy8), 64'(1));
        rst_ni = 1'b0;
        #1;
        check("midrst_ready",   64'(ready_o8), 64'(1));
        check("midrst_valid",   64'(valid_o8), 64'(0));
        check("midrst_busy",    64'(busy8), 64'(0));
        check("midrst_product", 64'(product8), 64'(0));
        q8.delete();
        @(posedge clk); #1 rst_ni = 1'b1;
        issue(1'b0, 1'b0, 16'h0007, 16'h0006);
        drain(1'b0);

        // clear during CALC, then clear together with a request in IDLE
        issue(1'b0, 1'b1, 16'h009C, 16'h0047);
        @(posedge clk); #1;
        @(posedge clk); #1 clear8 = 1'b1;
        @(posedge clk); #1 clear8 = 1'b0;
        q8.delete();
        check("clear_ready",   64'(ready_o8), 64'(1));
        check("clear_busy",    64'(busy8), 64'(0));
        check("clear_product", 64'(product8), 64'(16'h002A));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | valid_o8;
        end
        check("clear_no_valid", 64'(seen), 64'(0));
        @(posedge clk); #1;
        clear8 = 1'b1; valid_i8 = 1'b1; a8 = 8'h03; b8 = 8'h03;
        @(posedge clk); #1;
        clear8 = 1'b0; valid_i8 = 1'b0;
        @(negedge clk);
        check("clear_valid_busy",  64'(busy8), 64'(0));
        check("clear_valid_ready", 64'(ready_o8), 64'(1));

        // N=16 random sweep with corner operands mixed in
        for (int i = 0; i < 40; i++) begin
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : 16'($urandom);
            s = 1'($urandom_range(0, 1));
            issue(1'b1, s, a, b);
        end
        drain(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/booth_r4_seq_mul.md
Name: booth_r4_seq_mul

Overview:
Parametrised iterative radix-4 Booth multiplier that retires one Booth digit per clock.
- Each iteration recodes a 3-bit multiplier window into a digit in {-2,-1,0,+1,+2}, then adds the scaled multiplicand into a running partial product and shifts.
- Operands and result use valid/ready handshakes; signed or unsigned mode is selected per operation.
- Serves as the shared N-bit multiply unit for datapath blocks that previously used fixed 8-bit Booth partial-product cells.

Parameters:
- N, 8, operand width in bits; must be even and >= 4.
- W, N+2, internal extended operand width (derived; not overridable).
- ITER, W/2, number of Booth iterations per operation (derived).

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset, asynchronous assert, active-low.
- clear_i  input  1  synchronous abort; returns the block to IDLE.
- valid_i  input  1  operand request valid.
- ready_o  output  1  block can accept operands.
- signed_i  input  1  1 = two's-complement operands; 0 = unsigned.
- multiplicand_i  input  N  multiplicand.
- multiplier_i  input  N  multiplier.
- valid_o  output  1  product_o is valid.
- ready_i  input  1  consumer accepts the product.
- product_o  output  2N  product, modulo 2^(2N).
- busy_o  output  1  high while in CALC.

Behaviour:
Reset (rst_ni low), asynchronous:
- State = IDLE; ready_o=1; valid_o=0; busy_o=0; product_o=0; internal registers = 0.

States:
- IDLE: ready_o=1. When valid_i&&ready_o, capture both operands, extended to W bits (sign-extended if signed_i=1, zero-extended otherwise). Clear the accumulator, set count=0, go to CALC.
- CALC: ready_o=0, busy_o=1. Each cycle:
  - Digit i is formed from {mr[2i+1], mr[2i], mr[2i-1]}, with mr[-1]=0.
  - acc = acc + digit*mcand, computed W+1 bits wide and sign-extended.
  - The {acc, mr} pair is then shifted arithmetically right by 2.
  - count increments. When count==ITER-1 is processed, go to DONE.
- DONE: valid_o=1, and product_o holds the low 2N bits of the assembled result. Hold product_o stable while ready_i=0. When valid_o&&ready_i, go to IDLE and deassert valid_o on the next cycle.

Latency and throughput:
- Operands accepted at edge k; valid_o is first high after edge k+ITER (5 cycles for N=8).
- Minimum initiation interval is ITER+2 cycles. No back-to-back acceptance in DONE.

Signed mode result:
- Digit multiplication uses the W-bit operands, so unsigned N-bit values never alias negative. ITER=N/2+1 covers the extra window.
- -2*mcand is formed as (~mcand<<1)+2 within W+1 bits. No overflow is possible at W+1 bits.

clear_i:
- Highest priority after reset, in any state.
- Next state IDLE, valid_o=0, busy_o=0. product_o keeps its last value.
- clear_i together with valid_i in IDLE: the request is not accepted.

Other rules:
- valid_i high while in CALC/DONE is ignored; the requester must hold it until ready_o.
- Reset asserted mid-CALC or mid-DONE: immediate return to reset values; the in-flight result is lost.

Decomposition:
- Package booth_pkg:
  - state_e enum {IDLE, CALC, DONE}.
  - booth_digit_e enum {ZERO, POS1, POS2, NEG1, NEG2}.
  - function booth_recode(3-bit) -> booth_digit_e.
- Sub-module booth_r4_step (combinational, parameter W):
  - Inputs: acc, mcand, window.
  - Output: next acc before shift.
  - Same role as the existing 8-bit operand cell, generalised in width.
  - The top level holds the FSM, counter, shift registers and handshake.

Test Plan:
1. N=8, signed_i=1, -128 x -128 (0x80,0x80) -> product_o=0x4000, valid_o rises 5 cycles after acceptance.
2. N=8, signed_i=0, 255 x 255 -> 0xFE01. Then 0xC8 x 0x03 unsigned -> 0x0258. Same operands with signed_i=1 -> 0xFF58.
3. Backpressure: signed -1 x 127 (0xFF,0x7F), hold ready_i=0 for 3 cycles in DONE -> product_o stays 0xFF81, ready_o=0 throughout. Handshake releases it, and ready_o=1 on the next cycle.
4. Reset mid-operation: drop rst_ni during CALC cycle 2 -> all outputs at reset values immediately. A following 7 x 6 completes with 0x002A.
5. clear_i in CALC cycle 3 -> next cycle IDLE, ready_o=1, no valid_o pulse. clear_i with valid_i in IDLE -> no acceptance.
6. N=16 sweep, random signed/unsigned operands incl. 0x8000, 0xFFFF, 0 -> product matches the reference model modulo 2^32. Latency is exactly 9 cycles.
